ce_ls_sched: RTL and testbench
==============================

Name: ce_ls_sched

Overview:
- Scheduler in front of the CE least-square (LS) stage.
- On a start pulse it walks all (rx antenna, tx antenna, UE) combinations.
- For each combination it issues one block of cfg_fftpts subcarrier reads from the frequency-domain RX buffer.
- It frames each block with valid/sop/eop for the LS datapath and tags it with the tx/UE/rx indices used to select the LS coefficient sequence.
- It counts returning LS output eops and signals done when every block has drained.

Parameters:
- RD_LAT, 2, RX buffer read latency in cycles (1..4).
- NRX_MAX, 8, max rx antennas; sets the ls_rx_idx width (3).
- NUE_MAX, 16, max UEs; sets the ls_ue_idx width (4).
- ADDR_W, 14, RX buffer address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- start  in  1  one-cycle start pulse.
- abort  in  1  synchronous abort.
- cfg_fftpts  in  12  subcarriers per block (1..4095).
- cfg_num_rx  in  4  rx antennas (1..NRX_MAX).
- cfg_num_tx  in  3  tx antennas (1..4).
- cfg_num_ue  in  5  UEs (1..NUE_MAX).
- cfg_gap  in  4  idle cycles inserted between blocks.
- busy  out  1  high from an accepted start until done or abort.
- done  out  1  one-cycle pulse when all blocks have drained.
- err_cfg  out  1  one-cycle pulse when a start is rejected for bad config.
- rd_en  out  1  RX buffer read enable.
- rd_addr  out  ADDR_W  RX buffer read address.
- ls_ready  in  1  LS datapath ready (issue enable).
- ls_sink_valid  out  1  valid to the LS datapath.
- ls_sink_sop  out  1  start of block to the LS datapath.
- ls_sink_eop  out  1  end of block to the LS datapath.
- ls_tx_idx  out  2  tx antenna index for coefficient selection.
- ls_ue_idx  out  4  UE index for coefficient selection.
- ls_rx_idx  out  3  rx antenna index.
- ls_source_eop  in  1  eop from the LS output, used for drain counting.

Behaviour:
- Reset (async, rst_n=0): every output is 0, state is IDLE, all counters are 0, the delay pipeline is cleared. A reset mid-run drops the run with no done pulse.
- States:
  - IDLE: waits for start.
  - RUN: issues reads.
  - GAP: idles between blocks.
  - DRAIN: waits for outstanding blocks to complete.
- Start handling:
  - start in IDLE latches all cfg_* inputs.
  - If any count is 0, or cfg_num_rx>NRX_MAX, cfg_num_ue>NUE_MAX or cfg_num_tx>4: err_cfg pulses on the next cycle and the state stays IDLE.
  - Otherwise the state goes to RUN and busy=1 from the next cycle.
  - start while busy is ignored.
- Loop order: subcarrier counter sc innermost, then UE, then tx, then rx outermost.
- Read issue:
  - rd_en = (state==RUN) & ls_ready.
  - rd_addr = rx*cfg_fftpts + sc, where the rx base is a running accumulator (no multiplier).
  - Counters advance only on cycles with rd_en=1. ls_ready low freezes them with no skipped or repeated address.
- Block boundaries:
  - After issuing sc==cfg_fftpts-1, sc returns to 0 and ue/tx/rx advance with wrap.
  - If cfg_gap>0 the state goes to GAP for exactly cfg_gap cycles, then returns to RUN. If cfg_gap==0 blocks issue back-to-back.
  - The final block goes to DRAIN instead of GAP.
- Output framing and alignment:
  - ls_sink_valid = rd_en delayed RD_LAT cycles.
  - sop is asserted on the issue of sc==0; eop on the issue of sc==cfg_fftpts-1.
  - sop, eop and the three indices travel through the same RD_LAT delay, so they stay aligned with ls_sink_valid.
  - For cfg_fftpts==1, sop and eop are both asserted on the same beat.
  - ls_ready is an issue enable only; the downstream stage absorbs up to RD_LAT in-flight beats.
- Drain and done:
  - An eop counter (10 bits, total blocks = rx*tx*ue ≤ 512) increments on each ls_source_eop while busy.
  - done pulses the cycle after the count reaches the total while in DRAIN; busy drops on the same cycle.
  - ls_source_eop outside busy is ignored.
- Abort: takes priority over start. It returns the state to IDLE next cycle, clears counters and the delay pipeline (in-flight valids are suppressed), busy goes to 0, and no done pulse is produced.

Test Plan:
- Basic run:
  - Stimulus: fftpts=4, rx=1, tx=1, ue=2, gap=0, ls_ready=1, RD_LAT=2.
  - Required: rd_addr 0,1,2,3,0,1,2,3 on consecutive cycles.
  - Required: ls_sink_valid starts 2 cycles after the first rd_en; sop on beats 0 and 4; eop on beats 3 and 7; ls_ue_idx 0 then 1.
  - Required: done pulses one cycle after the second ls_source_eop.
- Loop order and addressing:
  - Stimulus: fftpts=3, rx=2, tx=2, ue=1, gap=2.
  - Required: blocks ordered (rx0,tx0), (rx0,tx1), (rx1,tx0), (rx1,tx1).
  - Required: rx1 addresses are 3..5.
  - Required: exactly 2 idle cycles between consecutive eop and sop on rd_en.
- Backpressure:
  - Stimulus: ls_ready low for 5 cycles mid-block.
  - Required: rd_en=0 and rd_addr held during the stall; the resulting sequence is contiguous with no gaps or duplicates.
- Config error:
  - Stimulus: start with cfg_num_ue=0.
  - Required: err_cfg pulses for 1 cycle, busy stays 0, rd_en never asserted.
  - Stimulus: cfg_fftpts=1.
  - Required: sop and eop are both asserted on every beat.
- Abort and reset:
  - Stimulus: abort in block 2.
  - Required: next cycle busy=0, rd_en=0, no further ls_sink_valid, no done pulse; a new start then runs cleanly from address 0.
  - Stimulus: rst_n asserted asynchronously mid-run.
  - Required: all outputs go to 0 immediately.
- Start while busy:
  - Stimulus: second start pulse during RUN.
  - Required: ignored; the original configuration and block count complete unchanged.

Source files
------------

// File: rtl/ce_ls_sched.sv
// LS-stage read scheduler: walks rx/tx/UE blocks of cfg_fftpts subcarriers, frames them, counts drain eops.
// Framing lags rd_en by RD_LAT cycles; ls_ready low freezes issue, in-flight beats still complete.
module ce_ls_sched #(
  parameter int RD_LAT  = 2,
  parameter int NRX_MAX = 8,
  parameter int NUE_MAX = 16,
  parameter int ADDR_W  = 14,
  localparam int RW = $clog2(NRX_MAX),
  localparam int UW = $clog2(NUE_MAX)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [11:0]       cfg_fftpts,
  input  logic [3:0]        cfg_num_rx,
  input  logic [2:0]        cfg_num_tx,
  input  logic [4:0]        cfg_num_ue,
  input  logic [3:0]        cfg_gap,
  output logic              busy,
  output logic              done,
  output logic              err_cfg,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              ls_ready,
  output logic              ls_sink_valid,
  output logic              ls_sink_sop,
  output logic              ls_sink_eop,
  output logic [1:0]        ls_tx_idx,
  output logic [UW-1:0]     ls_ue_idx,
  output logic [RW-1:0]     ls_rx_idx,
  input  logic              ls_source_eop
);

  localparam logic [3:0] NRX_LIM = 4'(NRX_MAX);
  localparam logic [4:0] NUE_LIM = 5'(NUE_MAX);

  typedef enum logic [1:0] {IDLE, RUN, GAP, DRAIN} state_t;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [1:0]    tx;
    logic [UW-1:0] ue;
    logic [RW-1:0] rx;
  } beat_t;

  state_t            state;
  logic [11:0]       fftpts_q;
  logic [3:0]        num_rx_q;
  logic [2:0]        num_tx_q;
  logic [4:0]        num_ue_q;
  logic [3:0]        gap_q;
  logic [11:0]       sc;
  logic [UW-1:0]     ue;
  logic [1:0]        tx;
  logic [RW-1:0]     rx;
  logic [ADDR_W-1:0] rx_base;
  logic [3:0]        gap_cnt;
  logic [9:0]        eop_cnt;
  logic [9:0]        total;
  logic [9:0]        eop_nxt;

  logic sc_last, ue_last, tx_last, rx_last, all_last, cfg_bad;
  beat_t beat_in;

  logic  [RD_LAT-1:0] vld_pipe;
  beat_t [RD_LAT-1:0] beat_pipe;

  assign rd_en   = (state == RUN) & ls_ready;
  assign rd_addr = rx_base + ADDR_W'(sc);

  assign sc_last  = (sc == fftpts_q - 12'd1);
  assign ue_last  = (5'(ue) == num_ue_q - 5'd1);
  assign tx_last  = (3'(tx) == num_tx_q - 3'd1);
  assign rx_last  = (4'(rx) == num_rx_q - 4'd1);
  assign all_last = sc_last & ue_last & tx_last & rx_last;

  assign cfg_bad = (cfg_fftpts == 12'd0) | (cfg_num_rx == 4'd0) | (cfg_num_tx == 3'd0) |
                   (cfg_num_ue == 5'd0) | (cfg_num_rx > NRX_LIM) | (cfg_num_ue > NUE_LIM) |
                   (cfg_num_tx > 3'd4);

  assign eop_nxt = eop_cnt + {9'd0, busy & ls_source_eop};

  always_comb begin
    beat_in = '0;
    if (rd_en) begin
      beat_in.sop = (sc == 12'd0);
      beat_in.eop = sc_last;
      beat_in.tx  = tx;
      beat_in.ue  = ue;
      beat_in.rx  = rx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err_cfg  <= 1'b0;
      fftpts_q <= '0;
      num_rx_q <= '0;
      num_tx_q <= '0;
      num_ue_q <= '0;
      gap_q    <= '0;
      sc       <= '0;
      ue       <= '0;
      tx       <= '0;
      rx       <= '0;
      rx_base  <= '0;
      gap_cnt  <= '0;
      eop_cnt  <= '0;
      total    <= '0;
    end else begin
      done    <= 1'b0;
      err_cfg <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        busy    <= 1'b0;
        sc      <= '0;
        ue      <= '0;
        tx      <= '0;
        rx      <= '0;
        rx_base <= '0;
        gap_cnt <= '0;
        eop_cnt <= '0;
      end else begin
        eop_cnt <= eop_nxt;
        case (state)
          IDLE: if (start) begin
            fftpts_q <= cfg_fftpts;
            num_rx_q <= cfg_num_rx;
            num_tx_q <= cfg_num_tx;
            num_ue_q <= cfg_num_ue;
            gap_q    <= cfg_gap;
            sc       <= '0;
            ue       <= '0;
            tx       <= '0;
            rx       <= '0;
            rx_base  <= '0;
            eop_cnt  <= '0;
            if (cfg_bad) begin
              err_cfg <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              total <= 10'(cfg_num_rx) * 10'(cfg_num_tx) * 10'(cfg_num_ue);
            end
          end
          RUN: if (ls_ready) begin
            if (!sc_last) begin
              sc <= sc + 12'd1;
            end else begin
              sc <= '0;
              // ue innermost, rx outermost; rx base steps by fftpts instead of multiplying
              if (!ue_last) begin
                ue <= ue + UW'(1);
              end else begin
                ue <= '0;
                if (!tx_last) begin
                  tx <= tx + 2'd1;
                end else begin
                  tx <= '0;
                  if (!rx_last) begin
                    rx      <= rx + RW'(1);
                    rx_base <= rx_base + ADDR_W'(fftpts_q);
                  end else begin
                    rx      <= '0;
                    rx_base <= '0;
                  end
                end
              end
              if (all_last) begin
                state <= DRAIN;
              end else if (gap_q != 4'd0) begin
                state   <= GAP;
                gap_cnt <= gap_q;
              end
            end
          end
          GAP: begin
            if (gap_cnt <= 4'd1) state <= RUN;
            else gap_cnt <= gap_cnt - 4'd1;
          end
          DRAIN: if (eop_nxt == total) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            eop_cnt <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Framing and indices ride the same delay as valid so they stay aligned with the read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      beat_pipe <= '0;
    end else if (abort) begin
      vld_pipe  <= '0;
      beat_pipe <= '0;
    end else begin
      vld_pipe[0]  <= rd_en;
      beat_pipe[0] <= beat_in;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        beat_pipe[i] <= beat_pipe[i-1];
      end
    end
  end

  assign ls_sink_valid = vld_pipe[RD_LAT-1];
  assign ls_sink_sop   = beat_pipe[RD_LAT-1].sop;
  assign ls_sink_eop   = beat_pipe[RD_LAT-1].eop;
  assign ls_tx_idx     = beat_pipe[RD_LAT-1].tx;
  assign ls_ue_idx     = beat_pipe[RD_LAT-1].ue;
  assign ls_rx_idx     = beat_pipe[RD_LAT-1].rx;

endmodule

// File: tb/tb_ce_ls_sched.sv
// Bench for ce_ls_sched: random and directed runs against a queue-based reference of the block walk.
module tb_ce_ls_sched;
  localparam int RD_LAT = 2;
  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [11:0]       cfg_fftpts = '0;
  logic [3:0]        cfg_num_rx = '0;
  logic [2:0]        cfg_num_tx = '0;
  logic [4:0]        cfg_num_ue = '0;
  logic [3:0]        cfg_gap = '0;
  logic              busy, done, err_cfg, rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              ls_ready = 1'b0;
  logic              ls_sink_valid, ls_sink_sop, ls_sink_eop;
  logic [1:0]        ls_tx_idx;
  logic [3:0]        ls_ue_idx;
  logic [2:0]        ls_rx_idx;
  logic              ls_source_eop = 1'b0;

  ce_ls_sched #(.RD_LAT(RD_LAT), .NRX_MAX(8), .NUE_MAX(16), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_fftpts(cfg_fftpts), .cfg_num_rx(cfg_num_rx), .cfg_num_tx(cfg_num_tx),
    .cfg_num_ue(cfg_num_ue), .cfg_gap(cfg_gap),
    .busy(busy), .done(done), .err_cfg(err_cfg), .rd_en(rd_en), .rd_addr(rd_addr),
    .ls_ready(ls_ready), .ls_sink_valid(ls_sink_valid), .ls_sink_sop(ls_sink_sop),
    .ls_sink_eop(ls_sink_eop), .ls_tx_idx(ls_tx_idx), .ls_ue_idx(ls_ue_idx),
    .ls_rx_idx(ls_rx_idx), .ls_source_eop(ls_source_eop)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int sop;
    int eop;
    int tx;
    int ue;
    int rx;
  } beat_t;

  beat_t iss_q[$];
  beat_t snk_q[$];
  logic  hist[$];
  bit    dl[3];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit m_busy = 0;
  int m_beats = 0, m_issued = 0, m_blocks = 0, m_eops = 0;
  int m_last_end = -1000, m_gap = 0, m_done_due = -1, m_err_due = -1;
  int ready_pct = 100;
  int stall_left = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: every cycle, judge outputs against the queued walk, then advance the model.
  initial begin
    beat_t b;
    logic exp_rd, exp_v, v;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        m_busy = 0; iss_q.delete(); snk_q.delete(); hist.delete();
        dl[0] = 0; dl[1] = 0; dl[2] = 0; ls_source_eop = 1'b0;
        m_done_due = -1; m_err_due = -1; m_eops = 0; m_issued = 0; m_beats = 0;
        continue;
      end
      check("busy", busy, m_busy);
      check("done", done, cyc == m_done_due);
      check("err_cfg", err_cfg, cyc == m_err_due);
      exp_rd = m_busy && (m_issued < m_beats) && ls_ready && (cyc - m_last_end > m_gap);
      check("rd_en", rd_en, exp_rd);
      if (m_busy && iss_q.size() > 0) check("rd_addr", rd_addr, iss_q[0].addr);
      if (rd_en) begin
        if (iss_q.size() > 0) begin
          b = iss_q.pop_front();
          m_issued++;
          if (b.eop != 0) m_last_end = cyc;
        end else check("rd_extra", 1, 0);
      end
      exp_v = (hist.size() == RD_LAT) ? hist[0] : 1'b0;
      check("sink_valid", ls_sink_valid, exp_v);
      if (ls_sink_valid) begin
        if (snk_q.size() > 0) begin
          b = snk_q.pop_front();
          check("sink_sop", ls_sink_sop, b.sop);
          check("sink_eop", ls_sink_eop, b.eop);
          check("tx_idx", ls_tx_idx, b.tx);
          check("ue_idx", ls_ue_idx, b.ue);
          check("rx_idx", ls_rx_idx, b.rx);
        end else check("sink_extra", 1, 0);
      end
      hist.push_back(rd_en);
      if (hist.size() > RD_LAT) void'(hist.pop_front());
      // LS datapath stand-in: returns each sunk eop a few cycles later
      v = dl[2]; dl[2] = dl[1]; dl[1] = dl[0]; dl[0] = ls_sink_valid & ls_sink_eop;
      ls_source_eop = v;
      if (v && m_busy) begin
        m_eops++;
        if (m_eops == m_blocks) begin
          m_done_due = cyc + 1;
          m_busy = 0;
        end
      end
      if (abort) begin
        m_busy = 0; iss_q.delete(); snk_q.delete();
        foreach (hist[i]) hist[i] = 1'b0;
        m_done_due = -1; m_eops = 0;
      end else if (start && !m_busy) begin
        int f, nr, nt, nu;
        f = cfg_fftpts; nr = cfg_num_rx; nt = cfg_num_tx; nu = cfg_num_ue;
        if (f == 0 || nr == 0 || nt == 0 || nu == 0 || nr > 8 || nu > 16 || nt > 4) begin
          m_err_due = cyc + 1;
        end else begin
          m_busy = 1; m_gap = cfg_gap; m_issued = 0; m_eops = 0; m_last_end = -1000;
          m_blocks = nr * nt * nu; m_beats = m_blocks * f;
          for (int r = 0; r < nr; r++)
            for (int t = 0; t < nt; t++)
              for (int u = 0; u < nu; u++)
                for (int s = 0; s < f; s++) begin
                  b.addr = (r * f + s) % (1 << ADDR_W);
                  b.sop = (s == 0); b.eop = (s == f - 1);
                  b.tx = t; b.ue = u; b.rx = r;
                  iss_q.push_back(b);
                  snk_q.push_back(b);
                end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (stall_left > 0) begin
        ls_ready = 1'b0;
        stall_left--;
      end else begin
        ls_ready = ($urandom_range(99, 0) < ready_pct);
      end
    end
  end

  task automatic pulse_start(input int f, input int nr, input int nt, input int nu, input int g);
    @(posedge clk); #1;
    cfg_fftpts = f[11:0]; cfg_num_rx = nr[3:0]; cfg_num_tx = nt[2:0];
    cfg_num_ue = nu[4:0]; cfg_gap = g[3:0];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_busy || busy) && n < 5000) begin
      @(posedge clk); #2; n++;
    end
    check("run_ends", n < 5000, 1);
    repeat (6) @(posedge clk);
    #2;
    check("iss_left", iss_q.size(), 0);
    check("snk_left", snk_q.size(), 0);
  endtask

  task automatic wait_issued(input int k);
    int n = 0;
    while (m_issued < k && n < 2000) begin
      @(posedge clk); #2; n++;
    end
    check("reach_issue", n < 2000, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_valid", ls_sink_valid, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    ready_pct = 100;
    pulse_start(4, 1, 1, 2, 0);
    wait_idle();
    pulse_start(3, 2, 2, 1, 2);
    wait_idle();

    pulse_start(6, 1, 1, 2, 1);
    wait_issued(3);
    stall_left = 5;
    wait_idle();

    pulse_start(4, 1, 1, 0, 0); wait_idle();
    pulse_start(0, 1, 1, 1, 0); wait_idle();
    pulse_start(4, 0, 1, 1, 0); wait_idle();
    pulse_start(4, 9, 1, 1, 0); wait_idle();
    pulse_start(4, 1, 5, 1, 0); wait_idle();
    pulse_start(4, 1, 0, 1, 0); wait_idle();
    pulse_start(4, 1, 1, 17, 0); wait_idle();

    ready_pct = 70;
    pulse_start(1, 2, 2, 2, 1);
    wait_idle();

    ready_pct = 100;
    pulse_start(4, 2, 1, 2, 1);
    wait_issued(5);
    pulse_abort();
    #2;
    check("abort_busy", busy, 0);
    check("abort_rd_en", rd_en, 0);
    repeat (8) @(posedge clk);
    pulse_start(5, 1, 1, 1, 0);
    wait_idle();

    @(posedge clk); #1;
    cfg_fftpts = 12'd4; cfg_num_rx = 4'd1; cfg_num_tx = 3'd1; cfg_num_ue = 5'd1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    wait_idle();

    pulse_start(3, 2, 1, 2, 1);
    wait_issued(2);
    pulse_start(7, 3, 3, 3, 0);
    wait_idle();

    for (int k = 0; k < 12; k++) begin
      ready_pct = $urandom_range(100, 40);
      pulse_start($urandom_range(8, 1), $urandom_range(3, 1), $urandom_range(3, 1),
                  $urandom_range(3, 1), $urandom_range(3, 0));
      wait_idle();
    end

    ready_pct = 100;
    pulse_start(8, 2, 2, 2, 0);
    wait_issued(10);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_rd_en", rd_en, 0);
    check("arst_rd_addr", rd_addr, 0);
    check("arst_valid", ls_sink_valid, 0);
    check("arst_sop", ls_sink_sop, 0);
    check("arst_eop", ls_sink_eop, 0);
    check("arst_idx", {ls_tx_idx, ls_ue_idx, ls_rx_idx}, 0);
    check("arst_done", done, 0);
    check("arst_err", err_cfg, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    pulse_start(2, 1, 1, 1, 0);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
